// File: rtl/oddr_tx_framer_if.sv
// Valid/ready payload handshake into the ODDR transmit framer.
interface oddr_tx_framer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/oddr_tx_framer.sv
// Transmit framer for the 1:4 DDR gearbox: training burst, then header + MSB-first nibbles.
// Optional CRC-4 trailer nibble when TX_CRC4_EN is defined.
module oddr_tx_framer #(
  parameter int DATA_W    = 16,
  parameter int TRAIN_LEN = 64
) (
  input  logic              i_sclk,
  input  logic              i_sync_reset,
  input  logic              i_start,
  oddr_tx_framer_if.slave   s_tx,
  output logic [3:0]        o_q,
  output logic              o_linked,
  output logic [15:0]       o_frame_cnt
);
  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2((TRAIN_LEN > NIB) ? TRAIN_LEN : NIB);

  typedef enum logic [2:0] {
    S_OFF, S_TRAIN, S_IDLE, S_HDR, S_DATA
`ifdef TX_CRC4_EN
    , S_CRC
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_q;
  logic [15:0]       r_frame_cnt;
  logic [3:0]        w_q_nxt;
  logic              w_last_nib;
  logic              w_final;
  logic              w_ready;
  logic              w_accept;

`ifdef TX_CRC4_EN
  logic [3:0] r_crc;

  // x^4+x+1, one payload bit per step, MSB of the nibble first
  function automatic logic [3:0] crc4_nib(input logic [3:0] c, input logic [3:0] n);
    logic [3:0] r;
    logic       fb;
    r = c;
    for (int i = 3; i >= 0; i--) begin
      fb = r[3] ^ n[i];
      r  = {r[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  assign w_final = (r_state == S_CRC);
`else
  assign w_final = w_last_nib;
`endif

  assign w_last_nib    = (r_state == S_DATA) && (r_cnt == '0);
  assign w_ready       = !i_start && !i_sync_reset && ((r_state == S_IDLE) || w_final);
  assign w_accept      = w_ready && s_tx.tx_valid;
  assign s_tx.tx_ready = w_ready;
  assign o_q           = r_q;
  assign o_frame_cnt   = r_frame_cnt;

  always_ff @(posedge i_sclk) begin
    if (i_sync_reset) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_q         <= 4'h0;
      r_frame_cnt <= 16'h0;
    end else begin
      r_state <= w_next;
      r_q     <= w_q_nxt;
      // one down-counter serves both the training burst and the nibble index
      if (i_start)
        r_cnt <= CNT_W'(TRAIN_LEN - 1);
      else if (r_state == S_HDR)
        r_cnt <= CNT_W'(NIB - 1);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_accept)
        r_shift <= s_tx.tx_data;
      else if (r_state == S_DATA)
        r_shift <= {r_shift[DATA_W-5:0], 4'h0};
      if (w_final && !i_start)
        r_frame_cnt <= r_frame_cnt + 16'h1;
    end
  end

`ifdef TX_CRC4_EN
  always_ff @(posedge i_sclk) begin
    if (i_sync_reset)
      r_crc <= 4'h0;
    else if (r_state == S_HDR)
      r_crc <= 4'h0;
    else if (r_state == S_DATA)
      r_crc <= crc4_nib(r_crc, r_shift[DATA_W-1 -: 4]);
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:   if (i_start) w_next = S_TRAIN;
      S_TRAIN: if (r_cnt == '0) w_next = S_IDLE;
      S_IDLE:  if (w_accept) w_next = S_HDR;
      S_HDR:   w_next = S_DATA;
      S_DATA: begin
        if (w_last_nib) begin
`ifdef TX_CRC4_EN
          w_next = S_CRC;
`else
          w_next = w_accept ? S_HDR : S_IDLE;
`endif
        end
      end
`ifdef TX_CRC4_EN
      S_CRC:   w_next = w_accept ? S_HDR : S_IDLE;
`endif
      default: w_next = S_OFF;
    endcase
    if (i_start)
      w_next = S_TRAIN;
  end

  always_comb begin
    w_q_nxt  = 4'h0;
    o_linked = 1'b0;
    case (r_state)
      S_TRAIN: w_q_nxt = 4'h3;
      S_IDLE:  o_linked = 1'b1;
      S_HDR: begin
        w_q_nxt  = 4'hC;
        o_linked = 1'b1;
      end
      S_DATA: begin
        w_q_nxt  = r_shift[DATA_W-1 -: 4];
        o_linked = 1'b1;
      end
`ifdef TX_CRC4_EN
      S_CRC: begin
        w_q_nxt  = r_crc;
        o_linked = 1'b1;
      end
`endif
      default: w_q_nxt = 4'h0;
    endcase
  end
endmodule

// File: tb/tb_oddr_tx_framer.sv
// Bench for oddr_tx_framer: directed link scenarios plus random traffic against a
// nibble-queue model of the transmitted symbol stream.
module tb_oddr_tx_framer;
  localparam int DATA_W    = 16;
  localparam int TRAIN_LEN = 8;
  localparam int NIB       = DATA_W / 4;
`ifdef TX_CRC4_EN
  localparam int FRAME_LEN = NIB + 2;
`else
  localparam int FRAME_LEN = NIB + 1;
`endif

  logic        sclk = 1'b0;
  logic        sync_reset;
  logic        start;
  logic [3:0]  q;
  logic        linked;
  logic [15:0] frame_cnt;

  oddr_tx_framer_if #(.DATA_W(DATA_W)) tx_if ();

  oddr_tx_framer #(.DATA_W(DATA_W), .TRAIN_LEN(TRAIN_LEN)) dut (
    .i_sclk       (sclk),
    .i_sync_reset (sync_reset),
    .i_start      (start),
    .s_tx         (tx_if),
    .o_q          (q),
    .o_linked     (linked),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 = off, 1 = training, 2 = linked
  int          m_mode = 0;
  int          m_train_left = 0;
  logic [3:0]  m_sym[$];
  logic [3:0]  m_prev = 4'h0;
  logic [15:0] m_fcnt = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] crc4_of(input logic [DATA_W-1:0] d);
    logic [3:0] r = 4'h0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (r[3] ^ d[i]) r = {r[2:0], 1'b0} ^ 4'h3;
      else             r = {r[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic push_frame(input logic [DATA_W-1:0] d);
    m_sym.push_back(4'hC);
    for (int i = NIB - 1; i >= 0; i--) m_sym.push_back(d[i*4 +: 4]);
`ifdef TX_CRC4_EN
    m_sym.push_back(crc4_of(d));
`endif
  endtask

  task automatic cycle(input logic rst, input logic st, input logic v, input logic [DATA_W-1:0] d);
    logic [3:0] cur;
    logic       rdy;
    @(negedge sclk);
    sync_reset     = rst;
    start          = st;
    tx_if.tx_valid = v;
    tx_if.tx_data  = d;
    #1;
    case (m_mode)
      0:       cur = 4'h0;
      1:       cur = 4'h3;
      default: cur = (m_sym.size() == 0) ? 4'h0 : m_sym[0];
    endcase
    rdy = (m_mode == 2) && (m_sym.size() <= 1) && !st && !rst;
    check("q", 32'(q), 32'(m_prev));
    check("linked", 32'(linked), 32'(m_mode == 2));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check("tx_ready", 32'(tx_if.tx_ready), 32'(rdy));
    @(posedge sclk);
    if (rst) begin
      m_mode = 0;
      m_sym.delete();
      m_prev = 4'h0;
      m_fcnt = 16'h0;
    end else begin
      m_prev = cur;
      if (st) begin
        m_mode       = 1;
        m_train_left = TRAIN_LEN;
        m_sym.delete();
      end else if (m_mode == 1) begin
        m_train_left--;
        if (m_train_left == 0) m_mode = 2;
      end else if (m_mode == 2) begin
        if (m_sym.size() > 0) begin
          void'(m_sym.pop_front());
          if (m_sym.size() == 0) m_fcnt++;
        end
        if (rdy && v) push_frame(d);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, DATA_W'($urandom));
  endtask

  initial begin
    sync_reset     = 1'b1;
    start          = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    repeat (2) @(posedge sclk);
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_linked", 32'(linked), 32'h0);

    cycle(1'b1, 1'b0, 1'b0, '0);
    // training burst, then reset mid-train, then train again
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(TRAIN_LEN + 3);
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b1, 16'h1111);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(TRAIN_LEN + 2);

    // single frame
    cycle(1'b0, 1'b0, 1'b1, 16'h1234);
    idle(FRAME_LEN + 2);

    // back-to-back frames
    cycle(1'b0, 1'b0, 1'b1, 16'hABCD);
    for (int i = 0; i < FRAME_LEN; i++) cycle(1'b0, 1'b0, 1'b1, 16'h5678);
    idle(FRAME_LEN + 2);

    // abort during the 2nd data nibble, then start racing tx_valid in IDLE
    cycle(1'b0, 1'b0, 1'b1, 16'h9ABC);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(TRAIN_LEN + 2);
    cycle(1'b0, 1'b1, 1'b1, 16'hDEAD);
    idle(TRAIN_LEN + 2);

    // CRC corner words
    cycle(1'b0, 1'b0, 1'b1, 16'h0001);
    idle(FRAME_LEN + 1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    idle(FRAME_LEN + 1);

    // frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    #2;
    release dut.r_frame_cnt;
    m_fcnt = 16'hFFFF;
    cycle(1'b0, 1'b0, 1'b1, 16'h4321);
    idle(FRAME_LEN + 1);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 3) != 0, DATA_W'($urandom));
    cycle(1'b0, 1'b1, 1'b0, '0);
    idle(TRAIN_LEN + 1);
    for (int i = 0; i < 500; i++)
      cycle(1'b0, 1'b0, $urandom_range(0, 1) != 0, DATA_W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
